// File: rtl/led_scanner_pkg.sv
// rtl/led_scanner_pkg.sv - shared types and helpers for the LED scanner
// Contents:
//   mode_e    : scan mode encoding as seen on the mode port
//   dir_e     : scan direction, UP moves toward the MSB of led_pos
//   pos_width : index width for a given LED count (at least 1 bit)
package led_scanner_pkg;

  typedef enum logic [1:0] {
    BOUNCE    = 2'b00,
    WRAP_UP   = 2'b01,
    WRAP_DOWN = 2'b10,
    HOLD      = 2'b11
  } mode_e;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  // A single LED still needs a 1-bit index so the position register exists.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_scanner_tick_divider.sv
// rtl/led_scanner_tick_divider.sv - step-period divider for the LED scanner
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears the count
//   en    : count enable; 0 freezes the count
//   div   : step period minus one, in clk cycles
//   step  : high in any enabled cycle whose rising edge completes a period
module tick_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] cnt;

  // Compare with >= so that lowering div below the running count produces a
  // step straight away instead of letting cnt run all the way round.
  assign step = en && (cnt >= div);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      if (step) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - one-hot LED scanner with bounce / wrap / hold modes
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset (pos 0, dir UP, divider cleared)
//   en      : scan enable; 0 freezes divider, position and direction
//   mode    : 00 BOUNCE, 01 WRAP_UP, 10 WRAP_DOWN, 11 HOLD (sampled on steps)
//   div     : step period minus one, in clk cycles
//   led_pos : registered one-hot decode of the current position
//   dir     : current direction, 1 toward MSB
//   tick    : one-cycle pulse in the first cycle a new led_pos is visible
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  output logic [N_LEDS-1:0] led_pos,
  output logic              dir,
  output logic              tick
);

  localparam int              POS_W   = pos_width(N_LEDS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

  logic             step;
  mode_e            mode_s;
  dir_e             dir_q, dir_next;
  logic [POS_W-1:0] pos_q, pos_next;

  assign mode_s = mode_e'(mode);

  function automatic logic [N_LEDS-1:0] decode(input logic [POS_W-1:0] p);
    logic [N_LEDS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .div   (div),
    .step  (step)
  );

  // Direction state register; it only moves on step cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= UP;
    end else if (step) begin
      dir_q <= dir_next;
    end
  end

  // Next direction and position for a step in the current mode.
  always_comb begin
    dir_next = dir_q;
    pos_next = pos_q;
    case (mode_s)
      BOUNCE: begin
        // With one LED there is nowhere to bounce: position and
        // direction both stay put.
        if (N_LEDS > 1) begin
          if (dir_q == UP) begin
            if (pos_q == POS_MAX) begin
              pos_next = pos_q - 1'b1;
              dir_next = DOWN;
            end else begin
              pos_next = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_next = pos_q + 1'b1;
              dir_next = UP;
            end else begin
              pos_next = pos_q - 1'b1;
            end
          end
        end
      end
      WRAP_UP: begin
        dir_next = UP;
        pos_next = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
      end
      WRAP_DOWN: begin
        dir_next = DOWN;
        pos_next = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
      end
      default: begin
        dir_next = dir_q;
        pos_next = pos_q;
      end
    endcase
  end

  // Direction output.
  always_comb begin
    dir = dir_q;
  end

  // Position, its one-hot image and tick all update on the same edge, so
  // tick marks exactly the first cycle of each new led_pos value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= '0;
      led_pos <= N_LEDS'(1);
      tick    <= 1'b0;
    end else begin
      tick <= step;
      if (step) begin
        pos_q   <= pos_next;
        led_pos <= decode(pos_next);
      end
    end
  end

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - self-checking bench for led_scanner
module tb_led_scanner;

  localparam int N_LEDS = 8;
  localparam int DIV_W  = 26;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [DIV_W-1:0]  div = '0;
  logic [N_LEDS-1:0] led_pos;
  logic              dir;
  logic              tick;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Reference state: plain integers describing the scanner's visible behaviour.
  int m_pos, m_dir, m_cnt, m_tick;

  led_scanner #(.N_LEDS(N_LEDS), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .div     (div),
    .led_pos (led_pos),
    .dir     (dir),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: enabled cycles are counted; a step fires when the count
  // has reached the current period limit, then the mode rule is applied.
  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0; m_dir = 1; m_cnt = 0; m_tick = 0;
    end else if (en) begin
      if (m_cnt >= int'(div)) begin
        m_cnt  = 0;
        m_tick = 1;
        case (mode)
          2'b00: if (N_LEDS > 1) begin
            int p;
            p = m_pos + (m_dir ? 1 : -1);
            if (p > N_LEDS - 1) begin p = N_LEDS - 2; m_dir = 0; end
            if (p < 0)          begin p = 1;          m_dir = 1; end
            m_pos = p;
          end
          2'b01: begin m_dir = 1; m_pos = (m_pos + 1) % N_LEDS; end
          2'b10: begin m_dir = 0; m_pos = (m_pos + N_LEDS - 1) % N_LEDS; end
          default: ;
        endcase
      end else begin
        m_cnt  = m_cnt + 1;
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      logic [N_LEDS-1:0] exp_led;
      exp_led = N_LEDS'(1) << m_pos;
      chk("model_led_pos", led_pos, exp_led);
      chk("model_dir", dir, m_dir[0]);
      chk("model_tick", tick, m_tick[0]);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [9];
    int ticks;
    logic [7:0] held;

    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    // Reset state.
    @(negedge clk);
    do_reset();
    cmp_on = 1'b1;
    chk("reset_led_pos", led_pos, 8'h01);
    chk("reset_dir", dir, 1'b1);
    chk("reset_tick", tick, 1'b0);

    // BOUNCE, div=0: one step per cycle, turns at the top.
    mode = 2'b00; div = 0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("bounce_seq", led_pos, seq[i]);
      chk("bounce_tick", tick, 1'b1);
      if (i == 6) chk("bounce_dir_top", dir, 1'b1);
      if (i == 7) chk("bounce_dir_turn", dir, 1'b0);
    end

    // Reset mid-scan at led_pos=20, dir=0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_led_pos", led_pos, 8'h01);
    chk("midreset_dir", dir, 1'b1);
    chk("midreset_tick", tick, 1'b0);

    // BOUNCE, div=3: one change every four cycles.
    do_reset();
    mode = 2'b00; div = 3; en = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      chk("div3_tick_phase", tick, (i % 4) == 0);
      if (i == 4)  chk("div3_pos1", led_pos, 8'h02);
      if (i == 7)  chk("div3_hold", led_pos, 8'h02);
      if (i == 12) chk("div3_pos3", led_pos, 8'h08);
    end
    chk("div3_tick_count", ticks, 3);

    // WRAP_UP past the top, then WRAP_DOWN past the bottom.
    do_reset();
    mode = 2'b01; div = 0; en = 1'b1;
    repeat (7) @(negedge clk);
    chk("wrap_up_at_top", led_pos, 8'h80);
    @(negedge clk);
    chk("wrap_up_wrapped", led_pos, 8'h01);
    mode = 2'b10;
    @(negedge clk);
    chk("wrap_down_wrapped", led_pos, 8'h80);
    chk("wrap_down_dir", dir, 1'b0);

    // Enable gap: the divider resumes its remaining count.
    do_reset();
    mode = 2'b00; div = 9; en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gap_led_pos", led_pos, 8'h01);
      chk("gap_tick", tick, 1'b0);
    end
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("resume_tick", tick, i == 5);
    end
    chk("resume_led_pos", led_pos, 8'h02);

    // HOLD: position frozen, tick still pulses every step.
    mode = 2'b11; div = 0;
    @(negedge clk);
    held  = led_pos;
    ticks = 1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      chk("hold_led_pos", led_pos, held);
    end
    chk("hold_tick_count", ticks, 20);

    // div lowered below the running count: step on the very next cycle.
    do_reset();
    mode = 2'b00; div = 100; en = 1'b1;
    repeat (50) @(negedge clk);
    chk("div_drop_no_early_tick", tick, 1'b0);
    div = 2;
    @(negedge clk);
    chk("div_drop_step", tick, 1'b1);
    chk("div_drop_led_pos", led_pos, 8'h02);

    // Randomised run against the model.
    div = 1;
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) div  = DIV_W'($urandom_range(0, 6));
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 SHALL have parameter N_LEDS, default 8, number of LEDs driven (legal range 1..64).
REQ-002 SHALL have parameter DIV_W, default 26, width of the step-period divider.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, scan enable; 0 freezes divider and position.
REQ-006 SHALL have port mode, input, 2 bits, scan mode: 00 BOUNCE, 01 WRAP_UP, 10 WRAP_DOWN, 11 HOLD.
REQ-007 SHALL have port div, input, DIV_W bits, step period minus one, in clk cycles.
REQ-008 SHALL have port led_pos, output, N_LEDS bits, one-hot lit-LED vector.
REQ-009 SHALL have port dir, output, 1 bit, current direction: 1 UP (toward MSB), 0 DOWN.
REQ-010 SHALL have port tick, output, 1 bit, one-cycle pulse coincident with each new led_pos value.

Function
REQ-011 SHALL hold a divider count cnt; each cycle with en=1: if cnt >= div, then step and cnt<=0; otherwise cnt<=cnt+1.
REQ-012 SHALL use >= so a div reduced below cnt causes a step on the next en=1 cycle, not a wrap of cnt.
REQ-013 SHALL step once every div+1 enabled cycles; div=0 SHALL step every enabled cycle.
REQ-014 SHALL, with en=0, hold cnt, position and dir unchanged and drive tick=0; the remaining count resumes when en returns to 1.
REQ-015 SHALL store position as an index pos (0..N_LEDS-1); led_pos SHALL be the registered one-hot decode of pos, exactly one bit set at all times.
REQ-016 SHALL apply the following on a step in BOUNCE: if dir=UP and pos<N_LEDS-1, pos+1; if dir=UP and pos=N_LEDS-1, pos-1 and dir<=DOWN; mirror behaviour for DOWN at pos 0.
REQ-017 SHALL apply the following on a step in WRAP_UP: dir<=UP; pos+1, wrapping N_LEDS-1 -> 0.
REQ-018 SHALL apply the following on a step in WRAP_DOWN: dir<=DOWN; pos-1, wrapping 0 -> N_LEDS-1.
REQ-019 SHALL, on a step in HOLD, leave pos and dir unchanged and still pulse tick.
REQ-020 SHALL sample mode only on step cycles; a mode change between steps takes effect at the next step.
REQ-021 SHALL, when N_LEDS=1, keep pos at 0 in every mode; dir follows REQ-017/018 and is otherwise unchanged.
REQ-022 SHALL register tick so that it is high exactly in the cycle the post-step led_pos is first visible.
REQ-023 SHALL treat the direction state machine as two states, UP and DOWN, transitioning only per REQ-016..018.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set pos=0 (led_pos=1), dir=UP, cnt=0 and tick=0, overriding en, mode and any pending step.
REQ-025 SHALL apply reset mid-scan with the same one-cycle effect; the first step after release occurs after div+1 enabled cycles.

Structure
REQ-026 SHALL place mode_e (BOUNCE, WRAP_UP, WRAP_DOWN, HOLD) and dir_e (DOWN=0, UP=1) in package led_scanner_pkg.
REQ-027 SHALL implement the divider (REQ-011..014) as sub-module tick_divider, with ports clk, reset, en, div, and step output.

Verification
REQ-028 SHALL cover: N_LEDS=8, div=0, BOUNCE, en=1 after reset -> led_pos 01,02,04,08,10,20,40,80,40,20 on consecutive cycles; dir falls to 0 with the 40 after 80.
REQ-029 SHALL cover: div=3, BOUNCE -> led_pos changes every 4 cycles; tick is high one cycle in four, aligned to each change.
REQ-030 SHALL cover: WRAP_UP at led_pos=80 -> 01 next step; WRAP_DOWN at 01 -> 80 next step with dir=0.
REQ-031 SHALL cover: div=9, en dropped for 10 cycles after 5 enabled cycles -> no change or tick while low; step occurs 5 enabled cycles after en returns.
REQ-032 SHALL cover: reset pulsed while led_pos=20 and dir=0 -> next cycle led_pos=01, dir=1, tick=0.
REQ-033 SHALL cover: HOLD for 20 steps -> led_pos constant and 20 tick pulses; div lowered from 100 to 2 while cnt=50 -> step on the next cycle.
